// File: rtl/ceespu_mul_ctrl.sv
// Sequencer for the ALU pipelined multiplier: holds operands, stalls for the latency, then delivers the low product.
// Optional build macro CEESPU_MUL_ZERO_SKIP_EN: zero operands bypass the multiplier and complete in one cycle.
module ceespu_mul_ctrl #(
   parameter int MUL_LATENCY = 3,
   parameter int WIDTH       = 32
) (
   input  logic             I_clk,
   input  logic             I_rst,
   input  logic             I_start,
   input  logic [WIDTH-1:0] I_dataA,
   input  logic [WIDTH-1:0] I_dataB,
   input  logic             I_flush,
   input  logic             I_hold,
   input  logic [WIDTH-1:0] I_mulResult,
   output logic [WIDTH-1:0] O_mulA,
   output logic [WIDTH-1:0] O_mulB,
   output logic             O_stall,
   output logic             O_busy,
   output logic             O_valid,
   output logic [WIDTH-1:0] O_result
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   localparam logic [2:0] LAT = 3'(MUL_LATENCY);

   state_e           state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] mula_q, mula_d;
   logic [WIDTH-1:0] mulb_q, mulb_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             valid_q, valid_d;
   logic             zero_op;

`ifdef CEESPU_MUL_ZERO_SKIP_EN
   assign zero_op = (I_dataA == '0) || (I_dataB == '0);
`else
   assign zero_op = 1'b0;
`endif

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         mula_q   <= '0;
         mulb_q   <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mula_q   <= mula_d;
         mulb_q   <= mulb_d;
         result_q <= result_d;
         valid_q  <= valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (I_flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (I_start) state_d = zero_op ? DONE : RUN;
            RUN:     if (cnt_q == LAT) state_d = DONE;
            DONE:    if (!I_hold) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Flush wins everywhere but leaves the last result in place.
   always_comb begin
      cnt_d    = cnt_q;
      mula_d   = mula_q;
      mulb_d   = mulb_q;
      result_d = result_q;
      valid_d  = valid_q;
      if (I_flush) begin
         cnt_d   = '0;
         valid_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (I_start) begin
                  cnt_d = '0;
                  if (zero_op) begin
                     result_d = '0;
                     valid_d  = 1'b1;
                  end else begin
                     mula_d = I_dataA;
                     mulb_d = I_dataB;
                  end
               end
            end
            RUN: begin
               if (cnt_q == LAT) begin
                  result_d = I_mulResult;
                  valid_d  = 1'b1;
               end else if (cnt_q < LAT) begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
            DONE: begin
               if (!I_hold) begin
                  valid_d = 1'b0;
                  cnt_d   = '0;
               end
            end
            default: begin
               cnt_d   = '0;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   // Nothing is accepted while reset is asserted, so stall is gated by it.
   always_comb begin
      O_stall = !I_rst && (((state_q == IDLE) && I_start && !I_flush) ||
                           (state_q == RUN) ||
                           ((state_q == DONE) && I_hold));
   end

   assign O_busy   = (state_q != IDLE);
   assign O_valid  = valid_q;
   assign O_result = result_q;
   assign O_mulA   = mula_q;
   assign O_mulB   = mulb_q;

endmodule

// File: tb/tb_ceespu_mul_ctrl.sv
// Bench for ceespu_mul_ctrl: directed timing checks plus randomized traffic against a transaction-level model.
module tb_ceespu_mul_ctrl;

   localparam int L = 3;

   logic        clk, rst, start, flush, hold;
   logic [31:0] da, db, mres;
   logic [31:0] mula, mulb, result;
   logic        stall, busy, valid;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   ceespu_mul_ctrl #(.MUL_LATENCY(L), .WIDTH(32)) dut (
      .I_clk(clk), .I_rst(rst), .I_start(start), .I_dataA(da), .I_dataB(db),
      .I_flush(flush), .I_hold(hold), .I_mulResult(mres),
      .O_mulA(mula), .O_mulB(mulb), .O_stall(stall), .O_busy(busy),
      .O_valid(valid), .O_result(result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Multiplier environment: L-deep register pipeline of the operand product.
   logic [31:0] mpipe [L];
   always @(posedge clk) begin
      mpipe[0] <= mula * mulb;
      for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
   end
   assign mres = mpipe[L-1];

   // Transaction model: an accepted op completes L+2 cycles after acceptance.
   bit          m_on = 0;
   logic        m_run = 0, m_valid = 0;
   int          m_age = 0;
   logic [31:0] m_a = 0, m_b = 0, m_res = 0, m_prod = 0;

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, act, exp);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   task automatic model_step();
      logic exp_stall;
      if (m_on) begin
         exp_stall = !rst && ((!m_run && !m_valid && start && !flush) || m_run || (m_valid && hold));
         chk1("stall", stall, exp_stall);
         chk1("busy", busy, m_run || m_valid);
         chk1("valid", valid, m_valid);
         chk32("result", result, m_res);
         chk32("mulA", mula, m_a);
         chk32("mulB", mulb, m_b);
      end
      if (rst) begin
         m_on = 1; m_run = 0; m_valid = 0; m_age = 0;
         m_a = 0; m_b = 0; m_res = 0; m_prod = 0;
      end else if (flush) begin
         m_run = 0; m_valid = 0;
      end else if (m_run) begin
         if (m_age == L + 1) begin
            m_run = 0; m_valid = 1; m_res = m_prod;
         end else begin
            m_age++;
         end
      end else if (m_valid) begin
         if (!hold) m_valid = 0;
      end else if (start) begin
`ifdef CEESPU_MUL_ZERO_SKIP_EN
         if (da == 0 || db == 0) begin
            m_valid = 1; m_res = 0;
         end else begin
            m_a = da; m_b = db; m_prod = da * db; m_run = 1; m_age = 1;
         end
`else
         m_a = da; m_b = db; m_prod = da * db; m_run = 1; m_age = 1;
`endif
      end
   endtask

   // One cycle: drive inputs after the edge, then check mid-cycle and advance the model.
   task automatic drv(input logic s, input logic [31:0] a, input logic [31:0] b,
                      input logic f, input logic h, input logic r);
      @(posedge clk); #1;
      cyc++;
      start = s; da = a; db = b; flush = f; hold = h; rst = r;
      @(negedge clk);
      model_step();
   endtask

   task automatic idle();
      drv(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      start = 0; da = 0; db = 0; flush = 0; hold = 0; rst = 0;

      // Reset with start asserted
      drv(1'b1, 32'd9, 32'd9, 1'b0, 1'b0, 1'b1);
      drv(1'b1, 32'd9, 32'd9, 1'b0, 1'b0, 1'b1);
      chk1("rst_valid", valid, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk32("rst_result", result, 32'd0);
      chk32("rst_mulA", mula, 32'd0);
      chk1("rst_stall", stall, 1'b0);
      idle();
      chk1("rel_stall", stall, 1'b0);

      // 7*6, no hold
      drv(1'b1, 32'd7, 32'd6, 1'b0, 1'b0, 1'b0);
      chk1("t1_stall_c0", stall, 1'b1);
      for (int i = 1; i <= L + 1; i++) begin
         idle();
         chk1("t1_stall_run", stall, 1'b1);
      end
      idle();
      chk1("t1_valid", valid, 1'b1);
      chk32("t1_result", result, 32'd42);
      chk1("t1_stall_done", stall, 1'b0);
      idle();
      chk1("t1_busy_after", busy, 1'b0);

      // 7*6 with hold in DONE for three cycles
      drv(1'b1, 32'd7, 32'd6, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= L + 1; i++) idle();
      for (int k = 0; k < 3; k++) begin
         drv(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
         chk1("t2_valid_hold", valid, 1'b1);
         chk32("t2_result_hold", result, 32'd42);
         chk1("t2_stall_hold", stall, 1'b1);
      end
      idle();
      chk1("t2_stall_release", stall, 1'b0);
      idle();
      chk1("t2_valid_cleared", valid, 1'b0);

      // Flush with counter at 1, then 3*5
      drv(1'b1, 32'd9, 32'd9, 1'b0, 1'b0, 1'b0);
      idle();
      drv(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
      idle();
      chk1("t3_busy_flushed", busy, 1'b0);
      chk1("t3_valid_flushed", valid, 1'b0);
      drv(1'b1, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= L + 1; i++) begin
         idle();
         chk1("t3_valid_low", valid, 1'b0);
      end
      idle();
      chk1("t3_valid", valid, 1'b1);
      chk32("t3_result", result, 32'd15);
      idle();

      // Back-to-back, second start right after DONE exit
      drv(1'b1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= L + 1; i++) idle();
      idle();
      chk1("t4a_valid", valid, 1'b1);
      chk32("t4a_result", result, 32'hFFFF_FFFE);
      drv(1'b1, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
      chk1("t4b_stall_accept", stall, 1'b1);
      for (int i = 1; i <= L + 1; i++) idle();
      idle();
      chk1("t4b_valid", valid, 1'b1);
      chk32("t4b_result", result, 32'h0000_0000);
      idle();

      // Reset during RUN abandons the op
      drv(1'b1, 32'd4, 32'd4, 1'b0, 1'b0, 1'b0);
      idle();
      drv(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      idle();
      chk1("t5_busy", busy, 1'b0);
      for (int i = 0; i < L + 3; i++) begin
         idle();
         chk1("t5_no_valid", valid, 1'b0);
      end

      // Zero operand
      drv(1'b1, 32'd0, 32'd5, 1'b0, 1'b0, 1'b0);
`ifdef CEESPU_MUL_ZERO_SKIP_EN
      idle();
      chk1("t6_valid_skip", valid, 1'b1);
      chk32("t6_result_skip", result, 32'd0);
      chk1("t6_stall_skip", stall, 1'b0);
`else
      for (int i = 1; i <= L + 1; i++) begin
         idle();
         chk1("t6_valid_low", valid, 1'b0);
      end
      idle();
      chk1("t6_valid", valid, 1'b1);
      chk32("t6_result", result, 32'd0);
`endif
      idle();

      // Randomized traffic, every cycle checked against the model
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] ra, rb;
         int sel;
         sel = $urandom_range(0, 7);
         ra = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(0, 15)) : $urandom;
         sel = $urandom_range(0, 7);
         rb = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(0, 15)) : $urandom;
         drv(1'($urandom_range(0, 1)), ra, rb,
             $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
